// File: rtl/definitions_pkg.sv
// definitions_pkg: instruction-write word type and default FIFO sizing constants
package definitions_pkg;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [4:0]  rd;
    logic [18:0] imm;
  } InstructionWrite;
  localparam int FIFO_DEPTH_LOG2      = 5;
  localparam int FIFO_AFULL_MARGIN    = 2;
  localparam int FIFO_AEMPTY_THRESH   = 2;
  localparam int FIFO_RST_BUSY_CYCLES = 2;
endpackage

// File: rtl/sdp_ram_sync.sv
// sdp_ram_sync: simple dual-port RAM, 1-cycle registered read with resettable output
module sdp_ram_sync #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/instr_fifo_param.sv
// instr_fifo_param: sync FIFO, standard or FWFT read; INSTR_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow ports
module instr_fifo_param
  import definitions_pkg::*;
#(
  parameter int WIDTH           = $bits(InstructionWrite),
  parameter int DEPTH_LOG2      = FIFO_DEPTH_LOG2,
  parameter int FWFT            = 0,
  parameter int AFULL_THRESH    = 2**DEPTH_LOG2 - FIFO_AFULL_MARGIN,
  parameter int AEMPTY_THRESH   = FIFO_AEMPTY_THRESH,
  parameter int RST_BUSY_CYCLES = FIFO_RST_BUSY_CYCLES
)(
  input  logic                  clk,
  input  logic                  srst,
  input  logic [WIDTH-1:0]      din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  wr_rst_busy,
  output logic                  rd_rst_busy
`ifdef INSTR_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] mem_cnt, mem_cnt_n, count_n;
  logic [7:0] busy_cnt;
  logic busy, full_r, empty_r, empty_n, wr_acc, pop, re;
  assign busy        = busy_cnt != '0;
  assign wr_rst_busy = busy;
  assign rd_rst_busy = busy;
  assign full        = full_r | busy;
  assign empty       = empty_r;
  // In FWFT mode the RAM output register is the prefetch stage: it holds the head
  // word while !empty_r, and is refilled whenever it is free or being popped.
  always_comb begin
    wr_acc    = wr_en & ~full_r & ~busy;
    pop       = rd_en & ~empty_r & ~busy;
    re        = (FWFT != 0) ? (mem_cnt != '0) & (empty_r | pop) : pop;
    count_n   = count + CW'(wr_acc) - CW'(pop);
    mem_cnt_n = mem_cnt + CW'(wr_acc) - CW'(re);
    empty_n   = (FWFT != 0) ? ~(re | (~empty_r & ~pop)) : count_n == '0;
  end
  always_ff @(posedge clk)
    if (srst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      mem_cnt      <= '0;
      busy_cnt     <= 8'(RST_BUSY_CYCLES);
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      busy_cnt     <= busy ? busy_cnt - 8'd1 : busy_cnt;
      wr_ptr       <= wr_ptr + DEPTH_LOG2'(wr_acc);
      rd_ptr       <= rd_ptr + DEPTH_LOG2'(re);
      count        <= count_n;
      mem_cnt      <= mem_cnt_n;
      full_r       <= count_n == CW'(DEPTH);
      empty_r      <= empty_n;
      almost_full  <= count_n >= CW'(AFULL_THRESH);
      almost_empty <= count_n <= CW'(AEMPTY_THRESH);
    end
`ifdef INSTR_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk)
    if (srst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow | (wr_en & full_r & ~busy);
      underflow <= underflow | (rd_en & empty_r & ~busy);
    end
`endif
  sdp_ram_sync #(.WIDTH(WIDTH), .AW(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .rst   (srst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (re),
    .raddr (rd_ptr),
    .rdata (dout)
  );
endmodule

// File: tb/tb_instr_fifo_param.sv
// tb_instr_fifo_param: directed checks of standard and FWFT instances of instr_fifo_param
module tb_instr_fifo_param;
  logic clk;
  logic srst_a, wr_a, rd_a, srst_b, wr_b, rd_b;
  logic [31:0] din_a, din_b, dout_a, dout_b;
  logic full_a, empty_a, af_a, ae_a, wb_a, rb_a;
  logic full_b, empty_b, af_b, ae_b, wb_b, rb_b;
  logic [5:0] cnt_a, cnt_b;
`ifdef INSTR_FIFO_ERR_FLAGS_EN
  logic ov_a, un_a, ov_b, un_b;
`endif
  int total = 0;
  int bad = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  instr_fifo_param #(.WIDTH(32), .FWFT(0)) u_a (
    .clk(clk), .srst(srst_a), .din(din_a), .wr_en(wr_a), .rd_en(rd_a), .dout(dout_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a), .count(cnt_a),
    .wr_rst_busy(wb_a), .rd_rst_busy(rb_a)
`ifdef INSTR_FIFO_ERR_FLAGS_EN
    , .overflow(ov_a), .underflow(un_a)
`endif
  );
  instr_fifo_param #(.WIDTH(32), .FWFT(1)) u_b (
    .clk(clk), .srst(srst_b), .din(din_b), .wr_en(wr_b), .rd_en(rd_b), .dout(dout_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b), .count(cnt_b),
    .wr_rst_busy(wb_b), .rd_rst_busy(rb_b)
`ifdef INSTR_FIFO_ERR_FLAGS_EN
    , .overflow(ov_b), .underflow(un_b)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    srst_a = 1; wr_a = 0; rd_a = 0; din_a = 0;
    srst_b = 1; wr_b = 0; rd_b = 0; din_b = 0;
    tick;
    srst_a = 0;
    chk("a_rst_count", cnt_a, 0);
    chk("a_rst_empty", empty_a, 1);
    chk("a_rst_aempty", ae_a, 1);
    chk("a_rst_afull", af_a, 0);
    chk("a_rst_dout", dout_a, 0);
    chk("a_rst_full", full_a, 1);
    chk("a_rst_wbusy", wb_a, 1);
    wr_a = 1; din_a = 32'hEE;
    tick;
    chk("a_busy1_w", wb_a, 1);
    chk("a_busy1_r", rb_a, 1);
    chk("a_busy1_full", full_a, 1);
    tick;
    wr_a = 0;
    chk("a_busy_end", wb_a, 0);
    chk("a_busy_end_full", full_a, 0);
    chk("a_busy_wr_ignored", cnt_a, 0);
    for (int i = 1; i <= 32; i++) begin
      wr_a = 1; din_a = 32'(i);
      tick;
      chk("a_fill_count", cnt_a, 64'(i));
      chk("a_fill_afull", af_a, 64'(i >= 30));
      chk("a_fill_full", full_a, 64'(i == 32));
      if (i == 1) chk("a_first_empty", empty_a, 0);
    end
    din_a = 32'h99;
    tick;
    wr_a = 0;
    chk("a_ovf_count", cnt_a, 32);
    chk("a_ovf_full", full_a, 1);
`ifdef INSTR_FIFO_ERR_FLAGS_EN
    chk("a_overflow", ov_a, 1);
`endif
    for (int i = 1; i <= 32; i++) begin
      rd_a = 1;
      tick;
      chk("a_drain_dout", dout_a, 64'(i));
      chk("a_drain_count", cnt_a, 64'(32 - i));
      chk("a_drain_aempty", ae_a, 64'(32 - i <= 2));
    end
    chk("a_drain_empty", empty_a, 1);
    tick;
    rd_a = 0;
    chk("a_udf_dout_hold", dout_a, 32'h20);
    chk("a_udf_count", cnt_a, 0);
`ifdef INSTR_FIFO_ERR_FLAGS_EN
    chk("a_underflow", un_a, 1);
`endif
    tick;
    chk("a_idle_dout_hold", dout_a, 32'h20);
`ifdef INSTR_FIFO_ERR_FLAGS_EN
    chk("a_underflow_sticky", un_a, 1);
`endif
    for (int k = 0; k < 5; k++) begin
      wr_a = 1; din_a = 32'h51 + 32'(k);
      tick;
    end
    chk("a_five", cnt_a, 5);
    for (int k = 0; k < 10; k++) begin
      wr_a = 1; rd_a = 1; din_a = 32'h60 + 32'(k);
      tick;
      chk("a_sim_count", cnt_a, 5);
      chk("a_sim_dout", dout_a, k < 5 ? 64'h51 + 64'(k) : 64'h60 + 64'(k - 5));
    end
    rd_a = 0;
    for (int k = 0; k < 27; k++) begin
      din_a = 32'h70 + 32'(k);
      tick;
    end
    chk("a_refill_count", cnt_a, 32);
    chk("a_refill_full", full_a, 1);
    rd_a = 1; din_a = 32'hDD;
    tick;
    wr_a = 0;
    chk("a_full_sim_count", cnt_a, 31);
    chk("a_full_sim_dout", dout_a, 32'h65);
    for (int k = 0; k < 14; k++) tick;
    rd_a = 0;
    chk("a_mid_count", cnt_a, 17);
    chk("a_mid_dout", dout_a, 32'h79);
    srst_a = 1; wr_a = 1; rd_a = 1; din_a = 32'h5A;
    tick;
    srst_a = 0; wr_a = 0; rd_a = 0;
    chk("a_mrst_count", cnt_a, 0);
    chk("a_mrst_dout", dout_a, 0);
    chk("a_mrst_empty", empty_a, 1);
    chk("a_mrst_aempty", ae_a, 1);
    chk("a_mrst_afull", af_a, 0);
    chk("a_mrst_full", full_a, 1);
`ifdef INSTR_FIFO_ERR_FLAGS_EN
    chk("a_mrst_underflow", un_a, 0);
    chk("a_mrst_overflow", ov_a, 0);
`endif
    tick;
    tick;
    chk("a_mrst_busy_end", wb_a, 0);
    chk("a_mrst_count2", cnt_a, 0);
    srst_b = 0;
    chk("b_rst_empty", empty_b, 1);
    chk("b_rst_dout", dout_b, 0);
    chk("b_rst_busy", rb_b, 1);
    tick;
    tick;
    chk("b_busy_end", rb_b, 0);
    wr_b = 1; din_b = 32'hAB;
    tick;
    wr_b = 0;
    chk("b_ab_empty1", empty_b, 1);
    chk("b_ab_count1", cnt_b, 1);
    tick;
    chk("b_ab_empty2", empty_b, 0);
    chk("b_ab_dout", dout_b, 32'hAB);
    chk("b_ab_count2", cnt_b, 1);
    rd_b = 1;
    tick;
    rd_b = 0;
    chk("b_pop_empty", empty_b, 1);
    chk("b_pop_count", cnt_b, 0);
    for (int k = 1; k <= 3; k++) begin
      wr_b = 1; din_b = 32'h11 * 32'(k);
      tick;
    end
    wr_b = 0;
    tick;
    chk("b_head_dout", dout_b, 32'h11);
    chk("b_head_count", cnt_b, 3);
    chk("b_head_empty", empty_b, 0);
    rd_b = 1;
    tick;
    chk("b_next1", dout_b, 32'h22);
    chk("b_next1_count", cnt_b, 2);
    tick;
    chk("b_next2", dout_b, 32'h33);
    tick;
    rd_b = 0;
    chk("b_last_empty", empty_b, 1);
    chk("b_last_count", cnt_b, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
